// File: rtl/fetch_pipe_ctrl_multi.sv
// -----------------------------------------------------------------------------
// fetch_pipe_ctrl_multi
//
// Fetch-pipe controller. Merges per-stage stall requests, sequences flushes
// coming from the main-pipe controller, and runs a handshaked invalidation of
// the fetch-side structures (bit0 = ITLB, bit1 = ICache, ...) before fetch is
// allowed to resume. Flush requests that arrive while a flush or invalidation
// is in progress are merged into a single-entry pending slot, so none is lost.
//
// Ports
//   i_clk              clock
//   i_rst_n            asynchronous reset, active low
//   i_stall_req        per-stage stall requests
//   i_flush_req        flush request pulse from the main pipe
//   i_flush_reason     reason code, valid with i_flush_req
//   i_flush_pc         redirect PC, valid with i_flush_req
//   i_inv_mask         targets to invalidate, valid with i_flush_req
//   i_inv_done         per-target invalidation complete (pulse or level)
//   o_stall            stall all fetch stages
//   o_flush            one-cycle flush pulse to the fetch stages
//   o_flush_target_pc  redirect PC of the current/last flush
//   o_flush_reason     reason of the current/last flush
//   o_invalidate       per-target invalidate request (level)
//   o_busy             controller is not idle
//   o_inv_timeout      sticky: an invalidation timed out
//   o_flush_count      number of flushes issued (wraps)
// -----------------------------------------------------------------------------
module fetch_pipe_ctrl_multi #(
   parameter int NUM_STALL_SRC = 4,
   parameter int NUM_INV       = 2,
   parameter int VADDR_WIDTH   = 32,
   parameter int REASON_WIDTH  = 3,
   parameter int INV_TIMEOUT   = 0
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [NUM_STALL_SRC-1:0] i_stall_req,
   input  logic                    i_flush_req,
   input  logic [REASON_WIDTH-1:0] i_flush_reason,
   input  logic [VADDR_WIDTH-1:0]  i_flush_pc,
   input  logic [NUM_INV-1:0]      i_inv_mask,
   input  logic [NUM_INV-1:0]      i_inv_done,
   output logic                    o_stall,
   output logic                    o_flush,
   output logic [VADDR_WIDTH-1:0]  o_flush_target_pc,
   output logic [REASON_WIDTH-1:0] o_flush_reason,
   output logic [NUM_INV-1:0]      o_invalidate,
   output logic                    o_busy,
   output logic                    o_inv_timeout,
   output logic [15:0]             o_flush_count
);

   localparam int TMO_W = (INV_TIMEOUT > 1) ? $clog2(INV_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_INV   = 2'd2
   } state_t;

   state_t                   r_state,       w_state_nxt;
   logic                     r_stall,       w_stall_nxt;
   logic                     r_flush,       w_flush_nxt;
   logic                     r_busy,        w_busy_nxt;
   logic                     r_tmo_flag,    w_tmo_flag_nxt;
   logic [VADDR_WIDTH-1:0]   r_pc,          w_pc_nxt;
   logic [REASON_WIDTH-1:0]  r_reason,      w_reason_nxt;
   logic [NUM_INV-1:0]       r_cur_mask,    w_cur_mask_nxt;
   logic [NUM_INV-1:0]       r_pend,        w_pend_nxt;
   logic [TMO_W-1:0]         r_tmo_cnt,     w_tmo_cnt_nxt;
   logic [15:0]              r_cnt,         w_cnt_nxt;
   logic                     r_slot_full,   w_slot_full_nxt;
   logic [VADDR_WIDTH-1:0]   r_slot_pc,     w_slot_pc_nxt;
   logic [REASON_WIDTH-1:0]  r_slot_reason, w_slot_reason_nxt;
   logic [NUM_INV-1:0]       r_slot_mask,   w_slot_mask_nxt;

   logic w_take_slot;
   logic w_start_new;
   logic w_tmo_hit;

   // Timeout fires on the last allowed INVALIDATE cycle; disabled when INV_TIMEOUT is 0.
   assign w_tmo_hit = (INV_TIMEOUT != 0) && (r_tmo_cnt == TMO_W'(INV_TIMEOUT - 1));

   // Next-state, pending-slot and registered-output computation.
   always_comb begin
      w_state_nxt       = r_state;
      w_tmo_flag_nxt    = r_tmo_flag;
      w_pc_nxt          = r_pc;
      w_reason_nxt      = r_reason;
      w_cur_mask_nxt    = r_cur_mask;
      w_pend_nxt        = r_pend;
      w_tmo_cnt_nxt     = r_tmo_cnt;
      w_cnt_nxt         = r_cnt;
      w_slot_full_nxt   = r_slot_full;
      w_slot_pc_nxt     = r_slot_pc;
      w_slot_reason_nxt = r_slot_reason;
      w_slot_mask_nxt   = r_slot_mask;
      w_take_slot       = 1'b0;
      w_start_new       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // A queued flush (captured on the way back to IDLE) is older than
            // any new request, so it launches first with the new one merged in.
            if (r_slot_full) begin
               w_take_slot = 1'b1;
            end else if (i_flush_req) begin
               w_start_new = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (r_cur_mask != '0) begin
               w_state_nxt   = ST_INV;
               w_pend_nxt    = r_cur_mask;
               w_tmo_cnt_nxt = '0;
            end else if (r_slot_full) begin
               w_take_slot = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_INV: begin
            // Exit is decided on the registered pending mask, so the last
            // invalidate bit is seen low for one cycle with stall still high.
            if (r_pend == '0) begin
               if (r_slot_full) begin
                  w_take_slot = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_tmo_hit) begin
               w_tmo_flag_nxt = 1'b1;
               w_pend_nxt     = '0;
               if (r_slot_full) begin
                  w_take_slot = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               // Done on a bit that is not pending is simply masked away.
               w_pend_nxt    = r_pend & ~i_inv_done;
               w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_pend_nxt  = '0;
         end
      endcase

      if (w_take_slot) begin
         w_state_nxt     = ST_FLUSH;
         w_slot_full_nxt = 1'b0;
         w_slot_mask_nxt = '0;
         if ((r_state == ST_IDLE) && i_flush_req) begin
            w_pc_nxt       = i_flush_pc;
            w_reason_nxt   = i_flush_reason;
            w_cur_mask_nxt = r_slot_mask | i_inv_mask;
         end else begin
            w_pc_nxt       = r_slot_pc;
            w_reason_nxt   = r_slot_reason;
            w_cur_mask_nxt = r_slot_mask;
         end
      end else if (w_start_new) begin
         w_state_nxt    = ST_FLUSH;
         w_pc_nxt       = i_flush_pc;
         w_reason_nxt   = i_flush_reason;
         w_cur_mask_nxt = i_inv_mask;
      end else begin
         w_cur_mask_nxt = w_cur_mask_nxt;
      end

      // Requests seen while not idle go to the slot after any consumption
      // above: newest PC/reason win, masks accumulate.
      if (i_flush_req && (r_state != ST_IDLE)) begin
         w_slot_full_nxt   = 1'b1;
         w_slot_pc_nxt     = i_flush_pc;
         w_slot_reason_nxt = i_flush_reason;
         w_slot_mask_nxt   = w_slot_mask_nxt | i_inv_mask;
      end else begin
         w_slot_full_nxt = w_slot_full_nxt;
      end

      if (w_state_nxt == ST_FLUSH) begin
         w_cnt_nxt = r_cnt + 16'd1;
      end else begin
         w_cnt_nxt = r_cnt;
      end

      w_flush_nxt = (w_state_nxt == ST_FLUSH);
      w_busy_nxt  = (w_state_nxt != ST_IDLE);
      w_stall_nxt = w_busy_nxt | (|i_stall_req);
   end

   // State and output registers; reset clears everything including the slot.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_stall       <= 1'b0;
         r_flush       <= 1'b0;
         r_busy        <= 1'b0;
         r_tmo_flag    <= 1'b0;
         r_pc          <= '0;
         r_reason      <= '0;
         r_cur_mask    <= '0;
         r_pend        <= '0;
         r_tmo_cnt     <= '0;
         r_cnt         <= 16'd0;
         r_slot_full   <= 1'b0;
         r_slot_pc     <= '0;
         r_slot_reason <= '0;
         r_slot_mask   <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_stall       <= w_stall_nxt;
         r_flush       <= w_flush_nxt;
         r_busy        <= w_busy_nxt;
         r_tmo_flag    <= w_tmo_flag_nxt;
         r_pc          <= w_pc_nxt;
         r_reason      <= w_reason_nxt;
         r_cur_mask    <= w_cur_mask_nxt;
         r_pend        <= w_pend_nxt;
         r_tmo_cnt     <= w_tmo_cnt_nxt;
         r_cnt         <= w_cnt_nxt;
         r_slot_full   <= w_slot_full_nxt;
         r_slot_pc     <= w_slot_pc_nxt;
         r_slot_reason <= w_slot_reason_nxt;
         r_slot_mask   <= w_slot_mask_nxt;
      end
   end

   assign o_stall           = r_stall;
   assign o_flush           = r_flush;
   assign o_flush_target_pc = r_pc;
   assign o_flush_reason    = r_reason;
   assign o_invalidate      = r_pend;
   assign o_busy            = r_busy;
   assign o_inv_timeout     = r_tmo_flag;
   assign o_flush_count     = r_cnt;

endmodule

// File: tb/tb_fetch_pipe_ctrl_multi.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fetch_pipe_ctrl_multi (INV_TIMEOUT = 8).
// Directed scenarios followed by random traffic, every cycle compared against
// a reference model that keeps queued flushes as a list of requests and folds
// them when the controller is ready for the next flush.
// -----------------------------------------------------------------------------
module tb_fetch_pipe_ctrl_multi;

   localparam int T_OUT = 8;

   logic        clk;
   logic        rst_n;
   logic [3:0]  stall_req;
   logic        flush_req;
   logic [2:0]  flush_reason;
   logic [31:0] flush_pc;
   logic [1:0]  inv_mask;
   logic [1:0]  inv_done;
   logic        o_stall, o_flush, o_busy, o_inv_timeout;
   logic [31:0] o_pc;
   logic [2:0]  o_reason;
   logic [1:0]  o_inv;
   logic [15:0] o_cnt;

   int n_chk = 0;
   int n_err = 0;

   fetch_pipe_ctrl_multi #(
      .NUM_STALL_SRC(4), .NUM_INV(2), .VADDR_WIDTH(32), .REASON_WIDTH(3), .INV_TIMEOUT(T_OUT)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall_req(stall_req), .i_flush_req(flush_req),
      .i_flush_reason(flush_reason), .i_flush_pc(flush_pc), .i_inv_mask(inv_mask),
      .i_inv_done(inv_done), .o_stall(o_stall), .o_flush(o_flush),
      .o_flush_target_pc(o_pc), .o_flush_reason(o_reason), .o_invalidate(o_inv),
      .o_busy(o_busy), .o_inv_timeout(o_inv_timeout), .o_flush_count(o_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [2:0]  rs;
      logic [1:0]  mk;
   } req_t;

   localparam int M_IDLE = 0;
   localparam int M_FLUSH = 1;
   localparam int M_INV = 2;

   req_t        waiting[$];
   int          m_mode;
   logic [1:0]  m_mask;
   logic [1:0]  m_rem;
   int          m_age;
   logic        e_stall, e_flush, e_busy, e_tmo;
   logic [31:0] e_pc;
   logic [2:0]  e_rs;
   logic [1:0]  e_inv;
   logic [15:0] e_cnt;

   task automatic model_reset();
      waiting.delete();
      m_mode = M_IDLE; m_mask = 2'b00; m_rem = 2'b00; m_age = 0;
      e_stall = 1'b0; e_flush = 1'b0; e_busy = 1'b0; e_tmo = 1'b0;
      e_pc = 32'd0; e_rs = 3'd0; e_inv = 2'b00; e_cnt = 16'd0;
   endtask

   // Collapse all waiting requests into one: latest PC/reason, union of masks.
   function automatic req_t fold_waiting();
      req_t r;
      r.pc = 32'd0; r.rs = 3'd0; r.mk = 2'b00;
      foreach (waiting[i]) begin
         r.pc = waiting[i].pc;
         r.rs = waiting[i].rs;
         r.mk = r.mk | waiting[i].mk;
      end
      waiting.delete();
      return r;
   endfunction

   task automatic begin_flush(input req_t r);
      m_mode = M_FLUSH;
      e_pc   = r.pc;
      e_rs   = r.rs;
      m_mask = r.mk;
      e_cnt  = e_cnt + 16'd1;
   endtask

   task automatic leave_work();
      if (waiting.size() > 0) begin_flush(fold_waiting());
      else m_mode = M_IDLE;
   endtask

   task automatic model_step();
      int   start;
      req_t cur;
      start  = m_mode;
      cur.pc = flush_pc; cur.rs = flush_reason; cur.mk = inv_mask;
      if (start == M_IDLE) begin
         if (waiting.size() > 0) begin
            if (flush_req) waiting.push_back(cur);
            begin_flush(fold_waiting());
         end else if (flush_req) begin
            begin_flush(cur);
         end
      end else if (start == M_FLUSH) begin
         if (m_mask != 2'b00) begin
            m_mode = M_INV; m_rem = m_mask; m_age = 0;
         end else begin
            leave_work();
         end
      end else begin
         if (m_rem == 2'b00) begin
            leave_work();
         end else if (m_age == T_OUT - 1) begin
            e_tmo = 1'b1; m_rem = 2'b00;
            leave_work();
         end else begin
            m_rem = m_rem & ~inv_done;
            m_age = m_age + 1;
         end
      end
      if (flush_req && start != M_IDLE) waiting.push_back(cur);
      e_flush = (m_mode == M_FLUSH);
      e_busy  = (m_mode != M_IDLE);
      e_stall = e_busy || (stall_req != 4'd0);
      e_inv   = (m_mode == M_INV) ? m_rem : 2'b00;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, ".stall"},   64'(o_stall),       64'(e_stall));
      chk({ph, ".flush"},   64'(o_flush),       64'(e_flush));
      chk({ph, ".pc"},      64'(o_pc),          64'(e_pc));
      chk({ph, ".reason"},  64'(o_reason),      64'(e_rs));
      chk({ph, ".inv"},     64'(o_inv),         64'(e_inv));
      chk({ph, ".busy"},    64'(o_busy),        64'(e_busy));
      chk({ph, ".timeout"}, 64'(o_inv_timeout), 64'(e_tmo));
      chk({ph, ".count"},   64'(o_cnt),         64'(e_cnt));
   endtask

   // One clock: inputs are stable across the rising edge, compare at the falling edge.
   task automatic tick(input string ph);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all(ph);
   endtask

   task automatic idle_inputs();
      stall_req = 4'd0; flush_req = 1'b0; flush_reason = 3'd0;
      flush_pc = 32'd0; inv_mask = 2'b00; inv_done = 2'b00;
   endtask

   task automatic set_req(input logic [31:0] pc, input logic [2:0] rs, input logic [1:0] mk);
      flush_req = 1'b1; flush_pc = pc; flush_reason = rs; inv_mask = mk;
   endtask

   initial begin
      bit seen;
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      #3;
      check_all("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: stall request in IDLE, one cycle latency
      stall_req = 4'b0100;
      repeat (3) tick("t1_stall");
      stall_req = 4'd0;
      tick("t1_release");
      chk("t1_stall_off", 64'(o_stall), 64'd0);

      // 2: flush without invalidation
      set_req(32'h8000_0100, 3'd5, 2'b00);
      tick("t2_flush");
      flush_req = 1'b0;
      chk("t2_pulse", 64'(o_flush), 64'd1);
      chk("t2_pc", 64'(o_pc), 64'h8000_0100);
      chk("t2_cnt", 64'(o_cnt), 64'd1);
      tick("t2_after");
      chk("t2_idle", 64'(o_busy), 64'd0);

      // 3: two-target invalidation with staggered done
      set_req(32'h0000_4000, 3'd2, 2'b11);
      tick("t3_flush");
      flush_req = 1'b0;
      tick("t3_inv0");
      chk("t3_inv11", 64'(o_inv), 64'd3);
      tick("t3_inv1");
      inv_done = 2'b01;
      tick("t3_done0");
      chk("t3_inv10", 64'(o_inv), 64'd2);
      inv_done = 2'b00;
      repeat (2) tick("t3_wait");
      inv_done = 2'b10;
      tick("t3_done1");
      chk("t3_inv00", 64'(o_inv), 64'd0);
      chk("t3_stall_held", 64'(o_stall), 64'd1);
      inv_done = 2'b00;
      tick("t3_exit");
      chk("t3_busy_off", 64'(o_busy), 64'd0);

      // 4: two requests queued during invalidation merge into one flush
      set_req(32'h0000_00A0, 3'd1, 2'b01);
      tick("t4_flush");
      flush_req = 1'b0;
      tick("t4_inv");
      set_req(32'h0000_0100, 3'd3, 2'b01);
      tick("t4_q1");
      set_req(32'h0000_0200, 3'd4, 2'b10);
      tick("t4_q2");
      idle_inputs();
      inv_done = 2'b01;
      tick("t4_done");
      inv_done = 2'b00;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick("t4_wait");
         seen = o_flush;
      end
      chk("t4_flush_seen", 64'(seen), 64'd1);
      chk("t4_pc", 64'(o_pc), 64'h200);
      tick("t4_reinv");
      chk("t4_inv11", 64'(o_inv), 64'd3);
      inv_done = 2'b11;
      tick("t4_done2");
      inv_done = 2'b00;
      repeat (2) tick("t4_settle");

      // 5: invalidation never completes -> timeout after 8 cycles
      set_req(32'h0000_0C00, 3'd6, 2'b11);
      tick("t5_flush");
      flush_req = 1'b0;
      repeat (T_OUT) tick("t5_inv");
      chk("t5_still_inv", 64'(o_inv), 64'd3);
      chk("t5_no_tmo_yet", 64'(o_inv_timeout), 64'd0);
      tick("t5_tmo");
      chk("t5_tmo", 64'(o_inv_timeout), 64'd1);
      chk("t5_inv_off", 64'(o_inv), 64'd0);
      chk("t5_idle", 64'(o_busy), 64'd0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         stall_req    = 4'($urandom_range(0, 15));
         flush_req    = ($urandom_range(0, 5) == 0);
         flush_pc     = $urandom;
         flush_reason = 3'($urandom_range(0, 7));
         inv_mask     = 2'($urandom_range(0, 3));
         inv_done     = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
         tick("rand");
      end
      idle_inputs();
      repeat (12) tick("drain");

      // 6: asynchronous reset during invalidation with a queued flush
      set_req(32'h0000_5000, 3'd7, 2'b11);
      tick("t6_flush");
      set_req(32'h0000_6000, 3'd1, 2'b01);
      tick("t6_inv");
      idle_inputs();
      chk("t6_inv_before", 64'(o_inv), 64'd3);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("t6_async");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick("t6_after");
      chk("t6_no_queued", 64'(o_cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
